// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the clock-divider bank.
// Referenced by clk_div_bank and clk_div_chan.
package clk_div_pkg;

    localparam int NCH_DEF     = 4;
    localparam int DW_DEF      = 8;
    localparam int DIV_RST_DEF = 21;

    // Width of a channel index. It is never narrower than one bit, so a
    // single-channel bank still has a real WR_CH port.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: free-running counter, active/staged divide value,
// and a registered square-wave output with a toggle pulse.
module clk_div_chan #(
    parameter int DW      = 8,
    parameter int DIV_RST = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          sync,
    input  logic          wr,
    input  logic [DW-1:0] wr_div,
    output logic          clk_out,
    output logic          tick,
    output logic          pend
);

    localparam logic [DW-1:0] RST_VAL = DW'(DIV_RST);

    logic [DW-1:0] cnt;
    logic [DW-1:0] act;
    logic [DW-1:0] stg;
    logic          term;
    logic          apply;

    // The counter never passes act, because act only changes when cnt is 0.
    // An equality test therefore cannot miss the terminal count.
    assign term  = (cnt == act);
    assign apply = sync || !en || term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            act     <= RST_VAL;
            stg     <= RST_VAL;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (sync || !en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (term) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
            end else begin
                cnt  <= cnt + DW'(1);
                tick <= 1'b0;
            end

            if (apply && pend) begin
                act <= stg;
            end

            // A same-cycle write restages after the older staged value is applied.
            if (wr) begin
                stg  <= wr_div;
                pend <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers sharing one clock.
// When the macro CLK_DIV_SYNC_EN is defined, SYNC phase-aligns all channels.
// Without that macro, the SYNC port is present but has no effect.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int DW      = DW_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     WR_EN,
    input  logic [ch_idx_w(NCH)-1:0] WR_CH,
    input  logic [DW-1:0]            WR_DIV,
    input  logic [NCH-1:0]           CH_EN,
    input  logic                     SYNC,
    output logic [NCH-1:0]           CLK_OUT,
    output logic [NCH-1:0]           TICK,
    output logic [NCH-1:0]           PEND
);

    localparam int CW = ch_idx_w(NCH);

    logic sync_int;

`ifdef CLK_DIV_SYNC_EN
    assign sync_int = SYNC;
`else
    logic unused_sync;
    assign unused_sync = SYNC;
    assign sync_int    = 1'b0;
`endif

    // A WR_CH value at or above NCH matches no channel, so that write is dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_div_chan #(
            .DW      (DW),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk     (CLK),
            .rst_n   (RST_N),
            .en      (CH_EN[i]),
            .sync    (sync_int),
            .wr      (WR_EN && (WR_CH == CW'(i))),
            .wr_div  (WR_DIV),
            .clk_out (CLK_OUT[i]),
            .tick    (TICK[i]),
            .pend    (PEND[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank with default parameters.
// It also covers the CLK_DIV_SYNC_EN build when that macro is defined.
module tb_clk_div_bank;

    localparam int NCH = 4;
    localparam int DW  = 8;

    logic           CLK;
    logic           RST_N;
    logic           WR_EN;
    logic [1:0]     WR_CH;
    logic [DW-1:0]  WR_DIV;
    logic [NCH-1:0] CH_EN;
    logic           SYNC;
    logic [NCH-1:0] CLK_OUT;
    logic [NCH-1:0] TICK;
    logic [NCH-1:0] PEND;

    int n_total = 0;
    int n_bad   = 0;

    clk_div_bank #(.NCH(NCH), .DW(DW), .DIV_RST(21)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .WR_EN   (WR_EN),
        .WR_CH   (WR_CH),
        .WR_DIV  (WR_DIV),
        .CH_EN   (CH_EN),
        .SYNC    (SYNC),
        .CLK_OUT (CLK_OUT),
        .TICK    (TICK),
        .PEND    (PEND)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write_div(input int ch, input int val);
        WR_EN  = 1'b1;
        WR_CH  = 2'(ch);
        WR_DIV = DW'(val);
        step();
        WR_EN  = 1'b0;
    endtask

    // Returns the number of edges until TICK[ch] is seen. The result is -1 if
    // no tick arrives within max edges.
    task automatic wait_tick(input int ch, input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            step();
            if (TICK[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    int n;

    initial begin
        RST_N  = 1'b0;
        WR_EN  = 1'b0;
        WR_CH  = '0;
        WR_DIV = '0;
        CH_EN  = '0;
        SYNC   = 1'b0;
        #1;
        check("rst_clk_out_async", 32'(CLK_OUT), 0);
        check("rst_pend_async",    32'(PEND),    0);
        steps(3);
        check("rst_tick", 32'(TICK), 0);
        RST_N = 1'b1;
        step();

        // ch0 at the default divide value: 22-cycle half-period, 44-cycle period
        CH_EN = 4'b0001;
        wait_tick(0, 60, n);
        check("ch0_first_half", n, 22);
        check("ch0_rise", 32'(CLK_OUT[0]), 1);
        wait_tick(0, 60, n);
        check("ch0_second_half", n, 22);
        check("ch0_fall", 32'(CLK_OUT[0]), 0);

        // ch1: a write in mid-period stays pending until the old half-period ends
        CH_EN[1] = 1'b1;
        steps(5);
        write_div(1, 3);
        check("ch1_pend_set", 32'(PEND[1]), 1);
        wait_tick(1, 60, n);
        check("ch1_old_half_done", n, 16);
        check("ch1_pend_clear", 32'(PEND[1]), 0);
        wait_tick(1, 60, n);
        check("ch1_new_half_a", n, 4);
        wait_tick(1, 60, n);
        check("ch1_new_half_b", n, 4);

        // ch2: a write while disabled is applied at once; div 0 toggles every cycle
        write_div(2, 0);
        step();
        check("ch2_pend_applied", 32'(PEND[2]), 0);
        CH_EN[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("ch2_tick_%0d", k), 32'(TICK[2]), 1);
            check($sformatf("ch2_out_%0d", k), 32'(CLK_OUT[2]), 32'(k % 2));
        end

        // ch3: a write on the terminal-count cycle applies the older pending value
        CH_EN[3] = 1'b1;
        step();
        write_div(3, 5);
        check("ch3_pend_5", 32'(PEND[3]), 1);
        steps(19);
        check("ch3_pre_term_tick", 32'(TICK[3]), 0);
        write_div(3, 7);
        check("ch3_term_tick", 32'(TICK[3]), 1);
        check("ch3_new_pend", 32'(PEND[3]), 1);
        wait_tick(3, 60, n);
        check("ch3_half_5", n, 6);
        check("ch3_pend_done", 32'(PEND[3]), 0);
        wait_tick(3, 60, n);
        check("ch3_half_7", n, 8);

        // reset in mid-operation discards the pending write on ch1
        write_div(1, 10);
        check("pre_rst_pend", 32'(PEND), 32'b0010);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_clk_out", 32'(CLK_OUT), 0);
        check("mid_rst_tick",    32'(TICK),    0);
        check("mid_rst_pend",    32'(PEND),    0);
        CH_EN = '0;
        steps(2);
        RST_N = 1'b1;
        step();
        CH_EN = 4'b0010;
        wait_tick(1, 60, n);
        check("post_rst_half", n, 22);
        check("post_rst_pend", 32'(PEND[1]), 0);

        // SYNC pulse in mid-period
        steps(5);
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
`ifdef CLK_DIV_SYNC_EN
        check("sync_out_low", 32'(CLK_OUT[1]), 0);
        wait_tick(1, 60, n);
        check("sync_realigned_half", n, 22);
`else
        check("sync_out_kept", 32'(CLK_OUT[1]), 1);
        wait_tick(1, 60, n);
        check("sync_ignored_half", n, 16);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
